// File: rtl/sys_tx_fifo.sv
// First-word-fall-through byte FIFO between the system controller transmit port and the UART transmitter.
// Registered FULL/EMPTY/COUNT flags; sticky OVERFLOW/UNDERFLOW for debug.
module sys_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] WR_DATA,
  input  logic             WR_INC,
  input  logic             RD_INC,
  input  logic             OVF_CLR,
  output logic [WIDTH-1:0] RD_DATA,
  output logic             FULL,
  output logic             EMPTY,
  output logic [PTR_W:0]   COUNT,
  output logic             OVERFLOW,
  output logic             UNDERFLOW
);

  localparam int unsigned PW = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             push, pop;

  // Acceptance uses only the registered flags, never same-cycle activity.
  always_comb begin
    push     = WR_INC && !full_q;
    pop      = RD_INC && !empty_q;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[PTR_W] != rd_ptr_d[PTR_W]) &&
               (wr_ptr_d[PTR_W-1:0] == rd_ptr_d[PTR_W-1:0]);
    count_d  = wr_ptr_d - rd_ptr_d;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (OVF_CLR) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    // A set event in the same cycle as a clear takes priority.
    if (WR_INC && full_q)  ovf_d = 1'b1;
    if (RD_INC && empty_q) unf_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is intentionally not reset; EMPTY masks stale contents.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= WR_DATA;
  end

  assign RD_DATA   = empty_q ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
  assign FULL      = full_q;
  assign EMPTY     = empty_q;
  assign COUNT     = count_q;
  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = unf_q;

endmodule

// File: tb/tb_sys_tx_fifo.sv
// Directed bench for sys_tx_fifo: reset, fall-through, fill/overflow, wrap, simultaneous events, async reset.
module tb_sys_tx_fifo;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] WR_DATA;
  logic       WR_INC;
  logic       RD_INC;
  logic       OVF_CLR;
  logic [7:0] RD_DATA;
  logic       FULL;
  logic       EMPTY;
  logic [3:0] COUNT;
  logic       OVERFLOW;
  logic       UNDERFLOW;

  int n_checks = 0;
  int n_errors = 0;

  sys_tx_fifo #(.WIDTH(8), .DEPTH(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .WR_DATA   (WR_DATA),
    .WR_INC    (WR_INC),
    .RD_INC    (RD_INC),
    .OVF_CLR   (OVF_CLR),
    .RD_DATA   (RD_DATA),
    .FULL      (FULL),
    .EMPTY     (EMPTY),
    .COUNT     (COUNT),
    .OVERFLOW  (OVERFLOW),
    .UNDERFLOW (UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge; outputs settle by #1 after the rising edge.
  task automatic step(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
    @(negedge CLK);
    WR_INC  = wr;
    WR_DATA = d;
    RD_INC  = rd;
    OVF_CLR = clr;
    @(posedge CLK);
    #1;
    WR_INC  = 1'b0;
    RD_INC  = 1'b0;
    OVF_CLR = 1'b0;
    WR_DATA = 8'h00;
  endtask

  initial begin
    RST = 1'b0; WR_DATA = 8'h00; WR_INC = 1'b0; RD_INC = 1'b0; OVF_CLR = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    repeat (5) step(1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_empty", 32'(EMPTY), 32'd1);
    check("rst_full", 32'(FULL), 32'd0);
    check("rst_count", 32'(COUNT), 32'd0);
    check("rst_rd_data", 32'(RD_DATA), 32'h00);
    check("rst_ovf", 32'(OVERFLOW), 32'd0);
    check("rst_unf", 32'(UNDERFLOW), 32'd0);

    // Single byte fall-through then pop.
    step(1'b1, 8'h11, 1'b0, 1'b0);
    check("ft_empty", 32'(EMPTY), 32'd0);
    check("ft_count", 32'(COUNT), 32'd1);
    check("ft_data", 32'(RD_DATA), 32'h11);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("pop1_empty", 32'(EMPTY), 32'd1);
    check("pop1_count", 32'(COUNT), 32'd0);
    check("pop1_data", 32'(RD_DATA), 32'h00);

    // Fill to DEPTH.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      check("fill_count", 32'(COUNT), 32'(i));
      check("fill_full", 32'(FULL), (i == 8) ? 32'd1 : 32'd0);
    end
    check("fill_head", 32'(RD_DATA), 32'h01);

    // Push while FULL with a simultaneous pop: push rejected.
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    check("ovf_flag", 32'(OVERFLOW), 32'd1);
    check("ovf_count", 32'(COUNT), 32'd7);
    check("ovf_head", 32'(RD_DATA), 32'h02);
    check("ovf_full", 32'(FULL), 32'd0);
    for (int i = 2; i <= 8; i++) begin
      check("drain_data", 32'(RD_DATA), 32'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("drain_empty", 32'(EMPTY), 32'd1);
    check("drain_ovf_sticky", 32'(OVERFLOW), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_clr", 32'(OVERFLOW), 32'd0);

    // Advance pointers to index 7, then fill across the wrap.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
      check("pre_data", 32'(RD_DATA), 32'h30);
    end
    for (int i = 0; i < 6; i++) begin
      check("pre_pop", 32'(RD_DATA), 32'(8'h30 + i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("pre_empty", 32'(EMPTY), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
      check("wrap_fill_count", 32'(COUNT), 32'(i + 1));
      check("wrap_fill_full", 32'(FULL), (i == 7) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 8; i++) begin
      check("wrap_data", 32'(RD_DATA), 32'(8'hA0 + i));
      check("wrap_count", 32'(COUNT), 32'(8 - i));
      check("wrap_full", 32'(FULL), (i == 0) ? 32'd1 : 32'd0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("wrap_empty", 32'(EMPTY), 32'd1);
    check("wrap_count0", 32'(COUNT), 32'd0);

    // Push and pop together on empty FIFO: pop rejected.
    step(1'b1, 8'h55, 1'b1, 1'b0);
    check("unf_flag", 32'(UNDERFLOW), 32'd1);
    check("unf_count", 32'(COUNT), 32'd1);
    check("unf_data", 32'(RD_DATA), 32'h55);
    check("unf_ovf", 32'(OVERFLOW), 32'd0);
    step(1'b1, 8'h66, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b0);
    check("mid_count3", 32'(COUNT), 32'd3);
    step(1'b1, 8'h88, 1'b1, 1'b0);
    check("mid_sim_count", 32'(COUNT), 32'd3);
    check("mid_sim_head", 32'(RD_DATA), 32'h66);
    check("mid_sim_empty", 32'(EMPTY), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("unf_clr", 32'(UNDERFLOW), 32'd0);
    check("unf_clr_count", 32'(COUNT), 32'd3);

    // Set wins over a simultaneous clear: pushing while not full and popping a non-empty FIFO set nothing,
    // so force an underflow on a drained FIFO together with OVF_CLR.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("setwin_pre_empty", 32'(EMPTY), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    check("setwin_unf", 32'(UNDERFLOW), 32'd1);

    // Async reset between edges with COUNT=5.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    check("prerst_count", 32'(COUNT), 32'd5);
    @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check("arst_count", 32'(COUNT), 32'd0);
    check("arst_empty", 32'(EMPTY), 32'd1);
    check("arst_full", 32'(FULL), 32'd0);
    check("arst_data", 32'(RD_DATA), 32'h00);
    check("arst_unf", 32'(UNDERFLOW), 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    check("post_data", 32'(RD_DATA), 32'h3C);
    check("post_count", 32'(COUNT), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
